// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues single-outstanding
// requests to instruction memory and buffers returned words toward decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_data,
  input  logic        instr_ready
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_DROP} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_tag_pc;
  logic [31:0]   r_fifo_pc   [FIFO_DEPTH];
  logic [31:0]   r_fifo_data [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_grant;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);

  // A free slot is reserved before issuing, so a kept response can always be pushed.
  assign imem_req  = (r_state == ST_RUN) && !w_full && !redirect_valid && !rst;
  assign imem_addr = r_fetch_pc;
  assign w_grant   = imem_req && imem_gnt;
  assign w_push    = (r_state == ST_WAIT) && imem_rvalid && !redirect_valid;

  assign instr_valid = !w_empty && !redirect_valid && !rst;
  assign instr_pc    = r_fifo_pc[r_rd_ptr];
  assign instr_data  = r_fifo_data[r_rd_ptr];
  assign w_pop       = instr_valid && instr_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_grant) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (redirect_valid)   w_state_nxt = imem_rvalid ? ST_RUN : ST_DROP;
        else if (imem_rvalid) w_state_nxt = ST_RUN;
      end
      ST_DROP: begin
        if (imem_rvalid) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_tag_pc   <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= {redirect_target[31:2], 2'b00};
    end else if (w_grant) begin
      r_fetch_pc <= r_fetch_pc + 32'd4;
      r_tag_pc   <= r_fetch_pc;
    end
  end

  // Flush wins over any same-cycle push or pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_valid) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_fifo_pc[r_wr_ptr]   <= r_tag_pc;
      r_fifo_data[r_wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized bench for fetch_unit against a queue-based
// reference model of the fetch PC, outstanding request and decode buffer.
module tb_fetch_unit;

  localparam logic [31:0] RPC   = 32'h0000_0100;
  localparam int          DEPTH = 2;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr_pc;
  logic [31:0] instr_data;
  logic        instr_ready;

  fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_pc(instr_pc), .instr_data(instr_data),
    .instr_ready(instr_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  // Reference model: fetch PC, one optional in-flight request, decode queue.
  ent_t        mq[$];
  logic [31:0] m_pc;
  logic [31:0] m_tag;
  bit          m_out;
  bit          m_keep;

  logic [31:0] glog[$];
  logic [31:0] plog[$];
  int          n_assert;
  int          n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_req();
    return !m_out && (mq.size() < DEPTH) && !redirect_valid && !rst;
  endfunction

  function automatic bit exp_valid();
    return (mq.size() != 0) && !redirect_valid && !rst;
  endfunction

  task automatic look();
    #2;
    chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req()});
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, exp_valid()});
    if (exp_req()) chk("imem_addr", imem_addr, m_pc);
    if (exp_valid()) begin
      chk("instr_pc", instr_pc, mq[0].pc);
      chk("instr_data", instr_data, mq[0].data);
    end
  endtask

  task automatic tick();
    bit ereq;
    bit eval;
    ereq = exp_req();
    eval = exp_valid();
    @(posedge clk);
    if (imem_req && imem_gnt) glog.push_back(imem_addr);
    if (instr_valid && instr_ready) plog.push_back(instr_pc);
    if (rst) begin
      m_pc  = RPC;
      m_out = 0;
      mq.delete();
    end else if (redirect_valid) begin
      m_pc = {redirect_target[31:2], 2'b00};
      mq.delete();
      if (m_out) begin
        if (imem_rvalid) m_out = 0;
        else m_keep = 0;
      end
    end else begin
      if (eval && instr_ready) void'(mq.pop_front());
      if (m_out && imem_rvalid) begin
        if (m_keep) mq.push_back('{pc: m_tag, data: imem_rdata});
        m_out = 0;
      end else if (ereq && imem_gnt) begin
        m_out  = 1;
        m_keep = 1;
        m_tag  = m_pc;
        m_pc   = m_pc + 32'd4;
      end
    end
    #1;
  endtask

  task automatic cyc();
    look();
    tick();
  endtask

  task automatic idle_inputs();
    redirect_valid  = 0;
    redirect_target = '0;
    imem_gnt        = 0;
    imem_rvalid     = 0;
    imem_rdata      = '0;
    instr_ready     = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    cyc();
    cyc();
    rst = 0;
    glog.delete();
    plog.delete();
  endtask

  task automatic fill_buffer();
    for (int i = 0; i < 8; i++) begin
      imem_gnt    = 1;
      imem_rvalid = m_out;
      imem_rdata  = $urandom;
      instr_ready = 0;
      cyc();
    end
    imem_gnt    = 0;
    imem_rvalid = 0;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    m_pc     = RPC;
    m_tag    = '0;
    m_out    = 0;
    m_keep   = 0;
    rst      = 1;
    idle_inputs();
    @(posedge clk);
    #1;

    // Reset state
    look();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    do_reset();
    look();
    chk("reset_addr", imem_addr, 32'h100);
    tick();

    // Sequential fetch with immediate responses
    do_reset();
    for (int i = 0; i < 9; i++) begin
      imem_gnt    = 1;
      imem_rvalid = m_out;
      imem_rdata  = $urandom;
      instr_ready = 1;
      cyc();
    end
    chk("n_grants", {31'd0, glog.size() >= 3}, 32'd1);
    chk("n_pops", {31'd0, plog.size() >= 3}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      if (i < glog.size()) chk("seq_addr", glog[i], 32'h100 + 32'(4 * i));
      if (i < plog.size()) chk("seq_pc", plog[i], 32'h100 + 32'(4 * i));
    end

    // Buffer full, then one pop releases the next request
    do_reset();
    fill_buffer();
    look();
    chk("full_req", {31'd0, imem_req}, 32'd0);
    chk("full_head", instr_pc, 32'h100);
    tick();
    instr_ready = 1;
    cyc();
    instr_ready = 0;
    imem_gnt    = 1;
    look();
    chk("resume_req", {31'd0, imem_req}, 32'd1);
    chk("resume_addr", imem_addr, 32'h108);
    tick();

    // Redirect in RUN with a full buffer
    do_reset();
    fill_buffer();
    redirect_valid  = 1;
    redirect_target = 32'h2003;
    look();
    chk("redir_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    redirect_valid = 0;
    look();
    chk("redir_req", {31'd0, imem_req}, 32'd1);
    chk("redir_addr", imem_addr, 32'h2000);
    tick();

    // Redirect while a response is pending: late data dropped
    do_reset();
    instr_ready = 1;
    imem_gnt    = 1;
    cyc();
    imem_gnt    = 0;
    imem_rvalid = 1;
    imem_rdata  = 32'h1111_2222;
    cyc();
    imem_rvalid = 0;
    imem_gnt    = 1;
    look();
    chk("pend_addr", imem_addr, 32'h104);
    tick();
    imem_gnt        = 0;
    redirect_valid  = 1;
    redirect_target = 32'h400;
    cyc();
    redirect_valid = 0;
    cyc();
    cyc();
    imem_rvalid = 1;
    imem_rdata  = 32'hDEAD_BEEF;
    look();
    chk("drop_req", {31'd0, imem_req}, 32'd0);
    tick();
    imem_rvalid = 0;
    imem_gnt    = 1;
    look();
    chk("drop_valid", {31'd0, instr_valid}, 32'd0);
    chk("after_drop_addr", imem_addr, 32'h400);
    chk("after_drop_req", {31'd0, imem_req}, 32'd1);
    tick();

    // Redirect coinciding with rvalid in WAIT
    imem_gnt        = 0;
    redirect_valid  = 1;
    redirect_target = 32'h800;
    imem_rvalid     = 1;
    imem_rdata      = 32'h5555_AAAA;
    cyc();
    redirect_valid = 0;
    imem_rvalid    = 0;
    // Grant withheld: request and address must hold
    for (int i = 0; i < 4; i++) begin
      look();
      chk("hold_req", {31'd0, imem_req}, 32'd1);
      chk("hold_addr", imem_addr, 32'h800);
      chk("hold_valid", {31'd0, instr_valid}, 32'd0);
      tick();
    end

    // Reset with a request outstanding, then a stray response
    imem_gnt = 1;
    cyc();
    imem_gnt = 0;
    rst      = 1;
    cyc();
    rst = 0;
    look();
    chk("post_rst_addr", imem_addr, 32'h100);
    imem_rvalid = 1;
    imem_rdata  = 32'hBAD0_BAD0;
    tick();
    imem_rvalid = 0;
    look();
    chk("stray_valid", {31'd0, instr_valid}, 32'd0);
    tick();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst             = ($urandom_range(0, 99) == 0);
      redirect_valid  = ($urandom_range(0, 9) == 0);
      redirect_target = $urandom;
      imem_gnt        = $urandom_range(0, 1) == 1;
      imem_rvalid     = m_out ? ($urandom_range(0, 4) < 2) : ($urandom_range(0, 49) == 0);
      imem_rdata      = $urandom;
      instr_ready     = ($urandom_range(0, 9) < 6);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch front end. Consumes the redirect target produced by the execute-stage branch/jump logic. Owns the architectural fetch PC and issues sequential requests to instruction memory over a request/grant/response handshake. Buffers returned instructions in a small FIFO toward decode, and squashes stale fetches whenever a redirect arrives.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC loaded on reset
FIFO_DEPTH, 2, instruction buffer entries (power of two, >= 2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
redirect_valid  in  1  execute stage: taken branch / jump / jalr this cycle
redirect_target  in  32  new PC; bits [1:0] ignored (treated as 0)
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address (word aligned)
imem_gnt  in  1  memory accepts request this cycle
imem_rvalid  in  1  response data valid
imem_rdata  in  32  instruction word
instr_valid  out  1  FIFO head valid toward decode
instr_pc  out  32  PC of head instruction
instr_data  out  32  head instruction word
instr_ready  in  1  decode accepts head

Behaviour:
- Reset, synchronous: fetch_pc=RESET_PC, state=RUN, FIFO empty, count=0.
- During rst: imem_req=0, instr_valid=0.
- States: RUN (no request outstanding), WAIT (one request outstanding, keep its data), DROP (one request outstanding, discard its data). Maximum one outstanding request.
- imem_req = (state==RUN) && (count<FIFO_DEPTH) && !redirect_valid && !rst. imem_addr = fetch_pc.
- Request holds addr stable until granted, unless a redirect intervenes.
- Grant (imem_req && imem_gnt): fetch_pc <= fetch_pc+4 (mod 2^32); capture issued pc in a tag register; RUN->WAIT.
- WAIT + rvalid, no redirect: push {tag_pc, imem_rdata} into FIFO; WAIT->RUN. FIFO slot is guaranteed by the issue rule.
- Push-to-instr_valid latency is 1 cycle. Next request can be issued the cycle after rvalid.
- Redirect (priority over everything):
  - fetch_pc <= {redirect_target[31:2],2'b00}; FIFO flushed (count=0).
  - RUN->RUN. WAIT->DROP if no rvalid this cycle, else ->RUN with the response discarded. DROP->DROP (pc updated), or ->RUN if rvalid this cycle.
  - First request to the new target appears the cycle after the redirect when nothing is outstanding.
- DROP + rvalid: response discarded; ->RUN.
- rvalid in RUN: protocol error; ignored, no push.
- Output: instr_valid = !empty && !redirect_valid. instr_pc/instr_data = FIFO head. Pop on instr_valid && instr_ready.
- Push and pop in the same cycle are legal; count unchanged.
- Flush has priority over a simultaneous push or pop.
- FIFO full (count==FIFO_DEPTH): no request issued; resumes the cycle after a pop lowers count.
- Reset asserted mid-operation with a request outstanding: state returns to RUN. A later stray rvalid is ignored (RUN rule).

Test Plan:
- Reset with RESET_PC=0x100, gnt=1, rvalid one cycle after each grant, ready=1 -> imem_addr sequence 0x100, 0x104, 0x108. instr_pc follows the same sequence, instr_data matches rdata.
- ready=0 with continuous memory responses -> exactly FIFO_DEPTH=2 instructions buffered (0x100, 0x104). imem_req low while full. After one pop, the next request to 0x108 issues the following cycle.
- Redirect to 0x2003 while in RUN with 2 buffered -> FIFO empties and instr_valid=0 that cycle. Next cycle imem_req=1, imem_addr=0x2000.
- Request to 0x104 granted, redirect to 0x400 before rvalid, rvalid 3 cycles later with 0xDEADBEEF -> data dropped and never reaches decode. Next request is 0x400, issued the cycle after that rvalid.
- Redirect coincides with rvalid in WAIT -> response discarded. Next cycle request to the target.
- gnt held low for 4 cycles -> imem_req stays high with addr stable and fetch_pc not incremented. rst asserted with a request outstanding -> imem_addr=RESET_PC after release, and a late rvalid produces no instr_valid.
